// File: rtl/madd_err_sweeper.sv
// madd_err_sweeper: exhaustive error-evaluation harness for an exact/approximate
// multiply-add pair. Sweeps every input vector, compares both responses LAT
// cycles later and accumulates mismatch count, max |error| (with first vector
// reaching it) and a saturating sum of |error|.
// Optional build macro: MADD_ERR_BIAS_EN adds a saturating signed bias_sum
// accumulating (approx_i - exact_i).
module madd_err_sweeper #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 12,
  parameter int LAT   = 1,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  vec_o,
  output logic             vec_valid_o,
  input  logic [OUT_W-1:0] exact_i,
  input  logic [OUT_W-1:0] approx_i,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    err_count,
  output logic [OUT_W-1:0] max_abs_err,
  output logic [IN_W-1:0]  max_err_vec,
  output logic [SUM_W-1:0] sum_abs_err
`ifdef MADD_ERR_BIAS_EN
  ,
  output logic signed [SUM_W:0] bias_sum
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          state;
  logic [CW-1:0]   drain_cnt;
  logic            samp_valid;
  logic [IN_W-1:0] samp_vec;
  logic [OUT_W-1:0] abs_err;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_next;

  // Sequencer: walk vectors 0..2^IN_W-1, then wait LAT cycles for the tail responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vec_o       <= '0;
      vec_valid_o <= 1'b0;
      done        <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SWEEP;
            vec_o       <= '0;
            vec_valid_o <= 1'b1;
          end
        end
        SWEEP: begin
          if (vec_o == '1) begin
            vec_valid_o <= 1'b0;
            drain_cnt   <= '0;
            if (LAT > 0) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            vec_o <= vec_o + IN_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == CW'(LAT - 1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy mirrors the state register.
  always_comb begin
    busy = (state != IDLE);
  end

  // Align each vector with the response that arrives LAT cycles later.
  generate
    if (LAT == 0) begin : g_nopipe
      assign samp_valid = vec_valid_o;
      assign samp_vec   = vec_o;
    end else begin : g_pipe
      logic [LAT-1:0]            pv;
      logic [LAT-1:0][IN_W-1:0]  pvec;
      // Shift valid/index pairs; oldest entry sits at index LAT-1.
      always_ff @(posedge clk) begin
        if (rst) begin
          pv   <= '0;
          pvec <= '0;
        end else begin
          pv   <= LAT'({pv, vec_valid_o});
          pvec <= (LAT*IN_W)'({pvec, vec_o});
        end
      end
      assign samp_valid = pv[LAT-1];
      assign samp_vec   = pvec[LAT-1];
    end
  endgenerate

  // Absolute error and saturating accumulation of it.
  always_comb begin
    abs_err  = (exact_i >= approx_i) ? (exact_i - approx_i) : (approx_i - exact_i);
    sum_ext  = {1'b0, sum_abs_err} + (SUM_W+1)'(abs_err);
    sum_next = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
  end

  // Statistics: cleared on reset or accepted start, updated per sampled response.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      err_count   <= '0;
      max_abs_err <= '0;
      max_err_vec <= '0;
      sum_abs_err <= '0;
    end else if (samp_valid) begin
      if (abs_err != '0) begin
        err_count <= err_count + (IN_W+1)'(1);
      end
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        max_err_vec <= samp_vec;
      end
      sum_abs_err <= sum_next;
    end
  end

`ifdef MADD_ERR_BIAS_EN
  logic signed [OUT_W:0]   bdiff;
  logic signed [SUM_W+1:0] bext;
  logic signed [SUM_W:0]   bnext;

  // Signed bias step; one guard bit detects overflow, then clamp to the rail.
  always_comb begin
    bdiff = $signed({1'b0, approx_i}) - $signed({1'b0, exact_i});
    bext  = (SUM_W+2)'(bias_sum) + (SUM_W+2)'(bdiff);
    if (bext[SUM_W+1] != bext[SUM_W]) begin
      bnext = bext[SUM_W+1] ? {1'b1, {SUM_W{1'b0}}} : {1'b0, {SUM_W{1'b1}}};
    end else begin
      bnext = bext[SUM_W:0];
    end
  end

  // Bias accumulator shares the statistics clear/update timing.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      bias_sum <= '0;
    end else if (samp_valid) begin
      bias_sum <= bnext;
    end
  end
`endif

endmodule
